// File: rtl/gate_arbiter_if.sv
// Bundle of lane request, passage sensor, grant/gate drive and occupancy status
// signals shared between the lanes and the gate arbiter.
interface gate_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             req_entry;
    logic             req_exit;
    logic             passed;
    logic             gnt_entry;
    logic             gnt_exit;
    logic             open_gate;
    logic             close_gate;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] occupancy;
    logic             full;

    // Lane/sensor side: raises requests and reports passage.
    modport master (
        output req_entry,
        output req_exit,
        output passed,
        input  gnt_entry,
        input  gnt_exit,
        input  open_gate,
        input  close_gate,
        input  busy,
        input  timeout_err,
        input  occupancy,
        input  full
    );

    // Arbiter side.
    modport slave (
        input  req_entry,
        input  req_exit,
        input  passed,
        output gnt_entry,
        output gnt_exit,
        output open_gate,
        output close_gate,
        output busy,
        output timeout_err,
        output occupancy,
        output full
    );
endinterface

// File: rtl/gate_arbiter.sv
// Shares one parking barrier between entry and exit lanes, tracks lot occupancy and
// aborts grants without passage. Optional macro OCCUPANCY_LIMIT_EN masks entry when full.
module gate_arbiter #(
    parameter int CAPACITY       = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    gate_arbiter_if.slave bus
);
    localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_CAP) begin
            return CNT_CAP;
        end else begin
            return cnt + CNT_W'(1);
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b0}}) begin
            return {CNT_W{1'b0}};
        end else begin
            return cnt - CNT_W'(1);
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    lane_t            last_served_r;
    lane_t            last_served_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic [CNT_W-1:0] occ_r;
    logic [CNT_W-1:0] occ_nxt_s;
    logic             timeout_nxt_s;
    logic             entry_eff_s;
    logic             full_s;

    logic             gnt_entry_r;
    logic             gnt_exit_r;
    logic             open_gate_r;
    logic             close_gate_r;
    logic             busy_r;
    logic             timeout_err_r;
    logic             gnt_entry_nxt_s;
    logic             gnt_exit_nxt_s;
    logic             open_gate_nxt_s;
    logic             close_gate_nxt_s;
    logic             busy_nxt_s;

    assign full_s = (occ_r == CNT_CAP);

`ifdef OCCUPANCY_LIMIT_EN
    // A full lot hides the entry request from arbitration entirely.
    assign entry_eff_s = bus.req_entry & ~full_s;
`else
    assign entry_eff_s = bus.req_entry;
`endif

    // State, round-robin pointer, OPEN timer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_served_r <= LANE_ENTRY;
            timer_r       <= {TMR_W{1'b0}};
            occ_r         <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            last_served_r <= last_served_nxt_s;
            timer_r       <= timer_nxt_s;
            occ_r         <= occ_nxt_s;
        end
    end

    // Next-state, arbitration, timeout and occupancy update.
    always_comb begin
        state_nxt_s       = state_r;
        last_served_nxt_s = last_served_r;
        timer_nxt_s       = timer_r;
        occ_nxt_s         = occ_r;
        timeout_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = {TMR_W{1'b0}};
                if (entry_eff_s && bus.req_exit) begin
                    state_nxt_s       = ST_OPEN;
                    last_served_nxt_s = (last_served_r == LANE_ENTRY) ? LANE_EXIT : LANE_ENTRY;
                end else if (entry_eff_s) begin
                    state_nxt_s       = ST_OPEN;
                    last_served_nxt_s = LANE_ENTRY;
                end else if (bus.req_exit) begin
                    state_nxt_s       = ST_OPEN;
                    last_served_nxt_s = LANE_EXIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OPEN: begin
                // Passage takes priority over a timer expiring on the same edge.
                if (bus.passed) begin
                    state_nxt_s = ST_CLOSE;
                    if (last_served_r == LANE_ENTRY) begin
                        occ_nxt_s = sat_inc(occ_r);
                    end else begin
                        occ_nxt_s = sat_dec(occ_r);
                    end
                end else if (timer_r == TMR_LAST) begin
                    state_nxt_s   = ST_CLOSE;
                    timeout_nxt_s = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            ST_CLOSE: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = {TMR_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = {TMR_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        gnt_entry_nxt_s  = 1'b0;
        gnt_exit_nxt_s   = 1'b0;
        open_gate_nxt_s  = 1'b0;
        close_gate_nxt_s = 1'b1;
        busy_nxt_s       = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            ST_OPEN: begin
                gnt_entry_nxt_s  = (last_served_nxt_s == LANE_ENTRY);
                gnt_exit_nxt_s   = (last_served_nxt_s == LANE_EXIT);
                open_gate_nxt_s  = 1'b1;
                close_gate_nxt_s = 1'b0;
                busy_nxt_s       = 1'b1;
            end
            ST_CLOSE: begin
                busy_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered gate and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_entry_r   <= 1'b0;
            gnt_exit_r    <= 1'b0;
            open_gate_r   <= 1'b0;
            close_gate_r  <= 1'b1;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            gnt_entry_r   <= gnt_entry_nxt_s;
            gnt_exit_r    <= gnt_exit_nxt_s;
            open_gate_r   <= open_gate_nxt_s;
            close_gate_r  <= close_gate_nxt_s;
            busy_r        <= busy_nxt_s;
            timeout_err_r <= timeout_nxt_s;
        end
    end

    assign bus.gnt_entry   = gnt_entry_r;
    assign bus.gnt_exit    = gnt_exit_r;
    assign bus.open_gate   = open_gate_r;
    assign bus.close_gate  = close_gate_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.occupancy   = occ_r;
    assign bus.full        = full_s;
endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: directed scenarios plus randomized lane traffic
// compared against a transaction-level model of grants, timeouts and occupancy.
module tb_gate_arbiter;
    localparam int CAPACITY       = 8;
    localparam int CNT_W          = 4;
    localparam int TIMEOUT_CYCLES = 16;
`ifdef OCCUPANCY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    // Model state: vehicles inside and which lane was served last (1 = exit).
    int   model_occ  = 0;
    bit   model_last = 1'b0;

    gate_arbiter_if #(.CNT_W(CNT_W)) bus ();

    gate_arbiter #(
        .CAPACITY(CAPACITY),
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {bus.gnt_entry, bus.gnt_exit, bus.open_gate, bus.close_gate,
                  bus.busy, bus.timeout_err, bus.occupancy, bus.full};

    function automatic logic [10:0] pack_exp(input bit ge, input bit gx, input bit og,
                                             input bit cg, input bit bz, input bit te,
                                             input int occ);
        logic [CNT_W-1:0] o;
        o = CNT_W'(occ);
        return {ge, gx, og, cg, bz, te, o, (occ == CAPACITY)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_entry = 1'b0;
        bus.req_exit  = 1'b0;
        bus.passed    = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_occ  = 0;
        model_last = 1'b0;
    endtask

    // One arbitration round from IDLE: request, grant, passage at OPEN cycle pass_cyc
    // (0 = never), then CLOSE and back to IDLE.
    task automatic serve(input bit re, input bit rx, input int pass_cyc, input string tag);
        bit eff_re;
        bit w;
        eff_re = re && !(LIMIT && model_occ == CAPACITY);
        bus.req_entry = re;
        bus.req_exit  = rx;
        if (!eff_re && !rx) begin
            repeat (3) begin
                step();
                checks++;
                if (obs !== pack_exp(0, 0, 0, 1, 0, 0, model_occ))
                    $display("FAIL %s no_grant: got %b expected %b", tag, obs, pack_exp(0, 0, 0, 1, 0, 0, model_occ));
                else passes++;
            end
            bus.req_entry = 1'b0;
            bus.req_exit  = 1'b0;
            return;
        end
        w = (eff_re && rx) ? !model_last : !eff_re;
        model_last = w;
        step();
        checks++;
        if (obs !== pack_exp(!w, w, 1, 0, 1, 0, model_occ))
            $display("FAIL %s grant: got %b expected %b", tag, obs, pack_exp(!w, w, 1, 0, 1, 0, model_occ));
        else passes++;
        bus.req_entry = 1'b0;
        bus.req_exit  = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            bus.passed = (k == pass_cyc);
            step();
            bus.passed = 1'b0;
            if (k == pass_cyc) begin
                model_occ = w ? ((model_occ > 0) ? model_occ - 1 : 0)
                              : ((model_occ < CAPACITY) ? model_occ + 1 : CAPACITY);
                checks++;
                if (obs !== pack_exp(0, 0, 0, 1, 1, 0, model_occ))
                    $display("FAIL %s close: got %b expected %b", tag, obs, pack_exp(0, 0, 0, 1, 1, 0, model_occ));
                else passes++;
                break;
            end else if (k == TIMEOUT_CYCLES) begin
                checks++;
                if (obs !== pack_exp(0, 0, 0, 1, 1, 1, model_occ))
                    $display("FAIL %s timeout: got %b expected %b", tag, obs, pack_exp(0, 0, 0, 1, 1, 1, model_occ));
                else passes++;
            end else begin
                checks++;
                if (obs !== pack_exp(!w, w, 1, 0, 1, 0, model_occ))
                    $display("FAIL %s open_c%0d: got %b expected %b", tag, k, obs, pack_exp(!w, w, 1, 0, 1, 0, model_occ));
                else passes++;
            end
        end
        step();
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, model_occ))
            $display("FAIL %s idle: got %b expected %b", tag, obs, pack_exp(0, 0, 0, 1, 0, 0, model_occ));
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_entry = 1'b1;
        bus.req_exit  = 1'b1;
        bus.passed    = 1'b1;
        step();
        step();
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, 0))
            $display("FAIL reset_hold: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, 0));
        else passes++;
        apply_reset();
        step();
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, 0))
            $display("FAIL reset_idle: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, 0));
        else passes++;
    endtask

    task automatic test_basic_entry();
        apply_reset();
        serve(1'b1, 1'b0, 4, "basic_entry");
    endtask

    task automatic test_tie();
        apply_reset();
        serve(1'b1, 1'b1, 1, "tie_first");
        serve(1'b1, 1'b1, 1, "tie_second");
        serve(1'b1, 1'b1, 2, "tie_third");
    endtask

    task automatic test_timeout();
        apply_reset();
        serve(1'b0, 1'b1, 0, "timeout_exit");
        serve(1'b1, 1'b0, 0, "timeout_entry");
    endtask

    task automatic test_boundaries();
        apply_reset();
        serve(1'b0, 1'b1, 2, "exit_empty");
        serve(1'b1, 1'b0, TIMEOUT_CYCLES, "pass_at_expiry");
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < CAPACITY; i++) serve(1'b1, 1'b0, 1, "fill");
        serve(1'b1, 1'b0, 1, "ninth_entry");
        serve(1'b0, 1'b1, 1, "exit_after_full");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        serve(1'b1, 1'b0, 1, "b2b_pre");
        bus.req_exit = 1'b1;
        step();
        model_last = 1'b1;
        bus.req_exit = 1'b0;
        bus.passed   = 1'b1;
        step();
        bus.passed    = 1'b0;
        bus.req_entry = 1'b1;
        model_occ = 0;
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 1, 0, 0))
            $display("FAIL b2b_close: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 1, 0, 0));
        else passes++;
        step();
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, 0))
            $display("FAIL b2b_idle_gap: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, 0));
        else passes++;
        step();
        model_last = 1'b0;
        bus.req_entry = 1'b0;
        checks++;
        if (obs !== pack_exp(1, 0, 1, 0, 1, 0, 0))
            $display("FAIL b2b_regrant: got %b expected %b", obs, pack_exp(1, 0, 1, 0, 1, 0, 0));
        else passes++;
        bus.passed = 1'b1;
        step();
        bus.passed = 1'b0;
        model_occ = 1;
        step();
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, 1))
            $display("FAIL b2b_end: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, 1));
        else passes++;
    endtask

    task automatic test_reset_mid_open();
        apply_reset();
        serve(1'b1, 1'b0, 1, "mid_pre1");
        serve(1'b1, 1'b0, 1, "mid_pre2");
        bus.req_exit = 1'b1;
        step();
        bus.req_exit = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_occ  = 0;
        model_last = 1'b0;
        checks++;
        if (obs !== pack_exp(0, 0, 0, 1, 0, 0, 0))
            $display("FAIL reset_mid_open: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, 0));
        else passes++;
        step();
        rst = 1'b0;
        serve(1'b1, 1'b1, 1, "post_reset_tie");
    endtask

    task automatic test_random();
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            int r;
            int gap;
            r = $urandom_range(1, 3);
            serve(r[0], r[1], $urandom_range(0, TIMEOUT_CYCLES), "random");
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.passed = 1'($urandom_range(0, 1));
                step();
                checks++;
                if (obs !== pack_exp(0, 0, 0, 1, 0, 0, model_occ))
                    $display("FAIL random_gap: got %b expected %b", obs, pack_exp(0, 0, 0, 1, 0, 0, model_occ));
                else passes++;
            end
            bus.passed = 1'b0;
        end
    endtask

    initial begin
        bus.req_entry = 1'b0;
        bus.req_exit  = 1'b0;
        bus.passed    = 1'b0;
        test_reset();
        test_basic_entry();
        test_tie();
        test_timeout();
        test_boundaries();
        test_full();
        test_back_to_back();
        test_reset_mid_open();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
